// File: rtl/incrementer_arbiter.sv
// Round-robin share of one LEN-bit incrementer among N requesters,
// with a 2-entry result queue on a valid/ready response port.

module incrementer #(
    parameter int LEN = 32
) (
    input  logic [LEN-1:0] operand,
    output logic [LEN-1:0] sum,
    output logic           carry_out
);

    assign {carry_out, sum} = {1'b0, operand} + {{LEN{1'b0}}, 1'b1};

endmodule

module incrementer_arbiter #(
    parameter int LEN = 32,
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req_valid,
    input  logic [N*LEN-1:0] req_value,
    output logic [N-1:0]     req_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [IDW-1:0]   rsp_id,
    output logic [LEN-1:0]   rsp_result,
    output logic             rsp_overflow
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [LEN-1:0] result;
        logic           ovf;
    } entry_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] last_q;
    logic [IDW-1:0] grant;
    logic [IDW:0]   cand;
    logic           found;
    logic           accept;
    logic           pop;
    logic [LEN-1:0] operand;
    logic [LEN-1:0] inc_sum;
    logic           inc_carry;
    entry_t         q0, q1, q0_d, q1_d, wr;

    // Search last+1 .. last+N, wrapping modulo N.
    always_comb begin
        grant = last_q;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = {1'b0, last_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(N)) begin
                cand = cand - (IDW+1)'(N);
            end
            if (!found && req_valid[cand[IDW-1:0]]) begin
                grant = cand[IDW-1:0];
                found = 1'b1;
            end
        end
    end

    // Gated by reset so nothing handshakes while reset is held.
    assign accept    = reset && (state_q != TWO) && found;
    assign req_ready = accept ? (N'(1) << grant) : '0;
    assign pop       = rsp_valid && rsp_ready;

    assign operand = req_value[int'(grant)*LEN +: LEN];

    incrementer #(
        .LEN(LEN)
    ) u_inc (
        .operand  (operand),
        .sum      (inc_sum),
        .carry_out(inc_carry)
    );

    assign wr = {grant, inc_sum, inc_carry};

    always_comb begin
        state_d = state_q;
        q0_d    = q0;
        q1_d    = q1;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    q0_d    = wr;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    q0_d = wr;
                end else if (accept) begin
                    state_d = TWO;
                    q1_d    = wr;
                end else if (pop) begin
                    state_d = EMPTY;
                    q0_d    = q1;
                    q1_d    = '0;
                end
            end
            TWO: begin
                if (pop) begin
                    state_d = ONE;
                    q0_d    = q1;
                    q1_d    = '0;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            last_q  <= IDW'(N-1);
            q0      <= '0;
            q1      <= '0;
        end else begin
            state_q <= state_d;
            q0      <= q0_d;
            q1      <= q1_d;
            if (accept) begin
                last_q <= grant;
            end
        end
    end

    assign rsp_valid    = (state_q != EMPTY);
    assign rsp_id       = q0.id;
    assign rsp_result   = q0.result;
    assign rsp_overflow = q0.ovf;

endmodule

// File: tb/tb_incrementer_arbiter.sv
// Scoreboard bench for incrementer_arbiter: a predictor queues expected
// responses at each accept, a monitor checks and pops them on the output.

module tb_incrementer_arbiter;

    localparam int LEN = 32;
    localparam int N   = 4;
    localparam int IDW = 2;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [LEN-1:0] res;
        logic           ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     req_valid;
    logic [N*LEN-1:0] req_value;
    logic [N-1:0]     req_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IDW-1:0]   rsp_id;
    logic [LEN-1:0]   rsp_result;
    logic             rsp_overflow;

    logic [LEN-1:0] val [N];

    exp_t           sb[$];
    int             checks = 0;
    int             passes = 0;
    logic [IDW-1:0] mdl_last = IDW'(N-1);
    bit             popped = 1'b0;

    int             p_occ;
    int             p_j;
    logic           p_acc;
    logic           p_f;
    logic [IDW-1:0] p_g;
    logic [N-1:0]   p_exp;
    exp_t           p_e;

    assign req_value = {val[3], val[2], val[1], val[0]};

    always #5 clk = ~clk;

    incrementer_arbiter #(
        .LEN(LEN),
        .N  (N),
        .IDW(IDW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_value   (req_value),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_overflow(rsp_overflow)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_overflow", rsp_overflow, 0);
        chk("rst_req_ready", req_ready, 0);
        sb.delete();
        mdl_last = IDW'(N-1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Monitor: head must match the oldest expected entry until popped.
    always @(negedge clk) begin
        popped = 1'b0;
        if (reset) begin
            chk("rsp_valid", rsp_valid, (sb.size() != 0));
            if (rsp_valid && sb.size() != 0) begin
                chk("rsp_id", rsp_id, sb[0].id);
                chk("rsp_result", rsp_result, sb[0].res);
                chk("rsp_overflow", rsp_overflow, sb[0].ovf);
                if (rsp_ready) begin
                    void'(sb.pop_front());
                    popped = 1'b1;
                end
            end
        end
    end

    // Predictor: reference arbitration and queue occupancy.
    always @(negedge clk) begin
        #1;
        if (reset) begin
            p_occ = sb.size() + (popped ? 1 : 0);
            p_acc = (p_occ < 2) && (|req_valid);
            p_g   = mdl_last;
            p_f   = 1'b0;
            for (int k = 1; k <= N; k++) begin
                p_j = (int'(mdl_last) + k) % N;
                if (!p_f && req_valid[p_j]) begin
                    p_g = IDW'(p_j);
                    p_f = 1'b1;
                end
            end
            p_exp = p_acc ? (N'(1) << p_g) : '0;
            chk("req_ready", req_ready, p_exp);
            if (p_acc) begin
                p_e.id  = p_g;
                p_e.res = val[p_g] + 32'd1;
                p_e.ovf = (val[p_g] == 32'hFFFF_FFFF);
                sb.push_back(p_e);
                mdl_last = p_g;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) val[i] = '0;
        #2;
        do_reset();

        // Single requester
        val[2]    = 32'h0000_0007;
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        #3;
        chk("t1_req_ready", req_ready, 4'b0100);
        step();
        req_valid = '0;
        chk("t1_valid", rsp_valid, 1);
        chk("t1_id", rsp_id, 2);
        chk("t1_result", rsp_result, 32'h0000_0008);
        chk("t1_ovf", rsp_overflow, 0);

        // Wrap-around
        val[1]    = 32'hFFFF_FFFF;
        req_valid = 4'b0010;
        step();
        chk("t2_wrap_res", rsp_result, 32'h0000_0000);
        chk("t2_wrap_ovf", rsp_overflow, 1);
        val[1] = 32'h0000_000F;
        step();
        req_valid = '0;
        chk("t2_res", rsp_result, 32'h0000_0010);
        chk("t2_ovf", rsp_overflow, 0);
        step();

        // Fairness / throughput
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) val[i] = 32'h1000 * i + i;
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) chk("t3_rsp_id", rsp_id, (i - 1) % 4);
            #3;
            chk("t3_grant", req_ready, 4'b0001 << (i % 4));
            step();
        end
        req_valid = '0;
        step();
        step();

        // Backpressure, stability, dropped request
        do_reset();
        rsp_ready = 1'b0;
        val[0]    = 32'h0000_000A;
        val[3]    = 32'h0000_000B;
        val[1]    = 32'h0000_000C;
        val[2]    = 32'h0000_000D;
        req_valid = 4'b1001;
        #3;
        chk("t4_first", req_ready, 4'b0001);
        step();
        #3;
        chk("t4_second", req_ready, 4'b1000);
        step();
        for (int c = 0; c < 5; c++) begin
            req_valid = (c == 1) ? 4'b1011 : 4'b1001;
            #3;
            chk("t4_blocked", req_ready, 0);
            chk("t4_hold_id", rsp_id, 0);
            chk("t4_hold_res", rsp_result, 32'h0000_000B);
            step();
        end
        rsp_ready = 1'b1;
        req_valid = 4'b0110;
        #3;
        chk("t4_pop_cycle", req_ready, 0);
        step();
        chk("t4_second_id", rsp_id, 3);
        #3;
        chk("t4_reassert", req_ready, 4'b0010);
        step();
        req_valid = '0;
        chk("t4_third_id", rsp_id, 1);
        chk("t4_third_res", rsp_result, 32'h0000_000D);
        step();
        step();

        // Reset while full
        do_reset();
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        step();
        step();
        chk("t6_full_valid", rsp_valid, 1);
        #2;
        do_reset();
        rsp_ready = 1'b1;
        #3;
        chk("t6_first_grant", req_ready, 4'b0001);
        step();
        req_valid = '0;
        step();
        step();

        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
